// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that shares a registered 4:1 mux among four valid/ready requesters
module mux4_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    input  logic             out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state, state_nxt;
    logic [1:0]       ptr, win;
    logic             has_win, load_en;
    logic [WIDTH-1:0] mux_data;
    // output stage occupancy, captured beat and rotation pointer; ptr only moves on an accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (load_en && has_win) begin
                out_data <= mux_data;
                out_sel  <= win;
                ptr      <= win + 2'd1;
            end
        end
    end
    // the register refills whenever it may load: full with a winner, empty without one
    always_comb state_nxt = load_en ? (has_win ? FULL : EMPTY) : state;
    // output stage view and the load permission derived from it
    always_comb begin
        out_valid = state == FULL;
        load_en   = !out_valid || out_ready;
    end
    // scan from ptr+3 down to ptr so the requester nearest ptr overrides the rest
    always_comb begin
        has_win = 1'b0;
        win     = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (in_valid[ptr + 2'(k)]) begin
                has_win = 1'b1;
                win     = ptr + 2'(k);
            end
        end
    end
    // data select on the winner index, every code covered
    always_comb begin
        case (win)
            2'd0: mux_data = in_data0;
            2'd1: mux_data = in_data1;
            2'd2: mux_data = in_data2;
            2'd3: mux_data = in_data3;
        endcase
    end
    // one-hot grant to the winner only when the register can take it and reset is released
    always_comb in_ready = (rst_n && has_win && load_en) ? (4'b0001 << win) : 4'b0000;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed plan plus randomized traffic checked against a behavioural model
module tb_mux4_rr_arbiter;
    localparam int WIDTH = 4;
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       in_valid = '0;
    logic [WIDTH-1:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_ready = 1'b1;
    int tests = 0;
    int fails = 0;
    int m_ptr = 0;
    int m_sel = 0;
    bit m_valid = 0;
    logic [WIDTH-1:0] m_data = '0;

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] data_of(input int i);
        return i == 0 ? in_data0 : i == 1 ? in_data1 : i == 2 ? in_data2 : in_data3;
    endfunction

    // first requester at or after m_ptr in circular order, -1 when none
    function automatic int winner();
        for (int k = 0; k < 4; k++)
            if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model state advances on every rising edge from the inputs seen there
    always @(posedge clk) begin
        int w;
        w = winner();
        if (!rst_n) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (!m_valid || out_ready) begin
            if (w >= 0) begin
                m_valid = 1; m_data = data_of(w); m_sel = w; m_ptr = (w + 1) % 4;
            end else m_valid = 0;
        end
    end

    // compare DUT against model every cycle on the falling edge
    always @(negedge clk) begin
        int w;
        logic [3:0] exp_ready;
        w = winner();
        exp_ready = (rst_n && w >= 0 && (!m_valid || out_ready)) ? 4'(1 << w) : 4'b0000;
        chk("model_in_ready", 32'(in_ready), 32'(exp_ready));
        chk("model_out_valid", 32'(out_valid), 32'(m_valid));
        chk("model_out_sel", 32'(out_sel), 32'(m_sel));
        chk("model_out_data", 32'(out_data), 32'(m_data));
    end

    task automatic cyc(input logic r, input logic [3:0] v, input logic ordy);
        @(posedge clk);
        #1;
        rst_n = r; in_valid = v; out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        // reset held, then idle
        cyc(0, 4'b1111, 1);
        chk("rst_ready", 32'(in_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_sel", 32'(out_sel), 32'h0);
        cyc(1, 4'b0000, 1);
        cyc(1, 4'b0000, 1);
        chk("idle_valid", 32'(out_valid), 32'h0);
        chk("idle_ready", 32'(in_ready), 32'h0);
        // single requester, then ptr=3 picks requester 3 over 0
        in_data2 = 4'hC; in_data3 = 4'h5;
        cyc(1, 4'b0100, 1);
        chk("single_ready", 32'(in_ready), 32'h4);
        cyc(1, 4'b1001, 1);
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", 32'(out_data), 32'hC);
        chk("single_sel", 32'(out_sel), 32'h2);
        chk("ptr3_ready", 32'(in_ready), 32'h8);
        // rotation from reset with all requesters active
        cyc(0, 4'b0000, 1);
        in_data0 = 4'hA; in_data1 = 4'hB; in_data2 = 4'hC; in_data3 = 4'hD;
        cyc(1, 4'b1111, 1);
        for (int i = 0; i < 5; i++) begin
            logic [WIDTH-1:0] rot_exp [4];
            rot_exp = '{4'hA, 4'hB, 4'hC, 4'hD};
            cyc(1, 4'b1111, 1);
            chk("rot_valid", 32'(out_valid), 32'h1);
            chk("rot_sel", 32'(out_sel), 32'(i % 4));
            chk("rot_data", 32'(out_data), 32'(rot_exp[i % 4]));
        end
        // backpressure while full with 0x7
        cyc(0, 4'b0000, 1);
        in_data0 = 4'h7;
        cyc(1, 4'b0001, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'b1111, 0);
            chk("bp_ready", 32'(in_ready), 32'h0);
            chk("bp_data", 32'(out_data), 32'h7);
            chk("bp_sel", 32'(out_sel), 32'h0);
        end
        cyc(1, 4'b1111, 1);
        chk("bp_release_ready", 32'(in_ready), 32'h2);
        cyc(1, 4'b0000, 1);
        chk("bp_release_sel", 32'(out_sel), 32'h1);
        // wrap and skip from ptr=3
        cyc(1, 4'b0100, 1);
        cyc(1, 4'b0011, 1);
        chk("wrap_ready0", 32'(in_ready), 32'h1);
        cyc(1, 4'b0011, 1);
        chk("wrap_ready1", 32'(in_ready), 32'h2);
        chk("wrap_sel0", 32'(out_sel), 32'h0);
        cyc(1, 4'b0100, 1);
        chk("wrap_sel1", 32'(out_sel), 32'h1);
        chk("wrap_ptr2", 32'(in_ready), 32'h4);
        // drain with an unknown on the unselected input
        in_data3 = 'x; in_data0 = 4'h9;
        cyc(1, 4'b0001, 1);
        cyc(1, 4'b0000, 1);
        chk("x_data", 32'(out_data), 32'h9);
        chk("x_valid", 32'(out_valid), 32'h1);
        cyc(1, 4'b0000, 1);
        chk("drain_valid", 32'(out_valid), 32'h0);
        in_data3 = 4'h3;
        // randomized traffic, occasional mid-operation reset
        for (int i = 0; i < 3000; i++) begin
            in_data0 = 4'($urandom); in_data1 = 4'($urandom);
            in_data2 = 4'($urandom); in_data3 = 4'($urandom);
            cyc($urandom_range(63) != 0, 4'($urandom), $urandom_range(3) != 0);
        end
        // fairness: requester 2 held among full contention is granted within 4 accepted beats
        begin
            int waited = 0;
            bit granted = 0;
            for (int i = 0; i < 4; i++) begin
                cyc(1, 4'b1111, 1);
                if (in_ready[2]) granted = 1;
                if (!granted) waited++;
            end
            chk("fair_grant", 32'(granted), 32'h1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 data mux among four requesters with valid/ready handshakes. Each cycle it picks one valid requester, steers that requester's data through the 4:1 select path, and registers the result into a single output stage. The block sits between four independent producers and one downstream consumer. It guarantees fair, starvation-free access and one-beat-per-cycle throughput.

## Interface
Parameters:
- WIDTH, default 4: data width of every input and output data bus.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  4  bit i set: requester i presents a beat on in_data_i.
- in_data0, in_data1, in_data2, in_data3  input  WIDTH each  requester data.
- in_ready  output  4  bit i set: requester i's beat is accepted at this clock edge. One-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered muxed data.
- out_sel  output  2  index of the requester whose beat is in out_data.
- out_ready  input  1  consumer accepts the output beat this cycle.

## Operation
- Transfer rule: a beat moves on a clock edge when valid and ready are both high on that side.
- The output register has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid || out_ready. This is combinational and the register may load only when it is high.
- Arbitration is combinational and evaluated every cycle:
  - Search in_valid starting at index ptr, then ptr+1, ptr+2, ptr+3, all modulo 4.
  - The first set bit is the winner w.
  - If no bit is set, there is no winner.
- in_ready[w] = load_en. Every other in_ready bit is 0. in_ready is 0 when there is no winner or load_en=0.
- On an edge with load_en=1 and a winner:
  - out_data <= in_data_w; out_sel <= w; out_valid <= 1.
  - ptr <= (w+1) mod 4. The 2-bit ptr wraps naturally.
- On an edge with load_en=1 and no winner: out_valid <= 0. out_data, out_sel and ptr hold.
- On an edge with load_en=0 (FULL and out_ready=0): all state holds. out_data and out_sel must stay stable while out_valid=1 and out_ready=0.
- ptr advances only on an accepted input beat. It never advances on idle cycles or stalled cycles.
- The mux select path is a case statement on the winner index with all 4 codes covered. It produces no latch and no X when inputs are known.
- Fairness: a requester that holds in_valid high is granted within 4 accepted beats.
- Requesters must hold in_valid and data stable until their in_ready. The arbiter does not check this.

## Timing
- Reset, on the first edge with rst_n=0:
  - out_valid=0, out_data=0, out_sel=0, ptr=0.
  - in_ready is forced to 0 while rst_n=0, regardless of inputs.
- Reset mid-operation: a beat held in the output register is dropped. No in_ready is asserted during the reset cycle.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 beat per cycle while out_ready=1 and any in_valid is set.
- Simultaneous accept and load: out_ready=1 with a new winner replaces the output beat in the same edge, with no bubble.
- in_ready depends combinationally on out_ready, in_valid and ptr. Consumers must not make out_ready depend combinationally on in_ready.

## Test plan
- Reset, then idle:
  - Stimulus: rst_n=0 for 2 cycles, then in_valid=0000 and out_ready=1.
  - Required: out_valid=0, out_data=0, out_sel=0 and in_ready=0000 throughout.
- Single requester:
  - Stimulus: in_valid=0100, in_data2=0xC, out_ready=1.
  - Required: in_ready=0100. Next cycle out_valid=1, out_data=0xC, out_sel=2.
  - Then ptr=3: assert in_valid=1001 and in_ready=1000 is required.
- Round-robin rotation:
  - Stimulus: from reset, in_valid=1111 with d0..d3=A,B,C,D and out_ready=1 continuously.
  - Required: out_sel=0,1,2,3,0 and out_data=A,B,C,D,A on consecutive cycles, with no bubbles.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while FULL with out_data=0x7 and in_valid=1111.
  - Required: in_ready=0000, out_data=0x7 and out_sel unchanged, ptr frozen.
  - Then release out_ready: the next grant follows the old ptr.
- Wrap and skip:
  - Stimulus: ptr=3 with in_valid=0011.
  - Required: grant is requester 0, then requester 1, after which ptr=2.
- Drain and X isolation:
  - Stimulus: d3='x, in_valid=0001, out_ready=1.
  - Required: out_data equals d0, with no X propagation.
  - Then in_valid=0000: out_valid drops to 0 after one cycle.
